// File: rtl/ifu_fetch_pkg.sv
// Shared constants, FSM encoding and helpers for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam int PC_W   = 64;   // fetch PC / memory address width
    localparam int INST_W = 32;   // instruction width delivered to decode
    localparam int IMEM_W = 64;   // instruction memory data width

    localparam logic [PC_W-1:0]   RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // issue the memory read for pc
        S_WAIT = 2'd1,   // wait for the read data
        S_OUT  = 2'd2    // present the bundle to decode
    } fetch_state_e;

    // Pick the 32-bit instruction out of an aligned doubleword using pc[2].
    function automatic logic [INST_W-1:0] select_half(input logic           upper,
                                                      input logic [IMEM_W-1:0] dword);
        return upper ? dword[IMEM_W-1:INST_W] : dword[INST_W-1:0];
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: redirect input, instruction-memory request/response, and
// the bundle handed to decode. "master" is the fetch stage, "slave" is the
// environment (memory, decode, execute/trap).
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    // Redirect from branch/jump/trap resolution
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    // Instruction memory request
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;

    // Instruction memory response
    logic              imem_resp_valid;
    logic              imem_resp_ready;
    logic [IMEM_W-1:0] imem_resp_data;
    logic              imem_resp_err;

    // Bundle to decode
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output imem_resp_ready,
        output if_valid, if_pc, if_inst, if_fault,
        input  if_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  imem_resp_ready,
        input  if_valid, if_pc, if_inst, if_fault,
        output if_ready
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one instruction-memory
// read at a time, extracts the 32-bit word and hands {pc, inst, fault} to
// decode. Redirects replace the PC and cancel any fetch they make stale.
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus
);

    fetch_state_e      r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_drop;      // a redirect hit while waiting: discard the next response
    logic [INST_W-1:0] r_inst_q;
    logic              r_fault_q;

    logic              w_req_valid;
    logic              w_resp_ready;
    logic              w_if_valid;
    logic              w_pc_aligned;

    assign w_pc_aligned = (r_pc[1:0] == 2'b00);

    // Handshake outputs decoded from the current state; all forced low in reset.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        w_req_valid  = 1'b0;
        w_resp_ready = 1'b0;
        w_if_valid   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_REQ:   w_req_valid  = ~bus.redirect_valid & w_pc_aligned;
                S_WAIT:  w_resp_ready = 1'b1;
                S_OUT:   w_if_valid   = ~bus.redirect_valid;
                default: ;
            endcase
        end
    end

    assign bus.imem_req_valid  = w_req_valid;
    assign bus.imem_req_addr   = {r_pc[PC_W-1:3], 3'b000};
    assign bus.imem_resp_ready = w_resp_ready;
    assign bus.if_valid        = w_if_valid;
    assign bus.if_pc           = r_pc;
    assign bus.if_inst         = r_inst_q;
    assign bus.if_fault        = r_fault_q;

    // Fetch FSM: PC sequencing, stale-response tracking and bundle capture.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_inst_q  <= '0;
            r_fault_q <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        r_pc <= bus.redirect_pc;
                    end else if (!w_pc_aligned) begin
                        // Misaligned PC faults without touching memory.
                        r_inst_q  <= NOP_INST;
                        r_fault_q <= 1'b1;
                        r_state   <= S_OUT;
                    end else if (bus.imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (r_drop || bus.redirect_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                            if (bus.redirect_valid) begin
                                r_pc <= bus.redirect_pc;
                            end
                        end else begin
                            r_inst_q  <= select_half(r_pc[2], bus.imem_resp_data);
                            r_fault_q <= bus.imem_resp_err;
                            r_state   <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        // The request is still in flight; remember to discard it.
                        r_pc   <= bus.redirect_pc;
                        r_drop <= 1'b1;
                    end
                end

                S_OUT: begin
                    if (bus.redirect_valid) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= S_REQ;
                    end else if (bus.if_ready) begin
                        r_pc      <= r_pc + PC_W'(4);
                        r_fault_q <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end

                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch. A small behavioural memory answers
// requests after a programmable delay; each test task drives one scenario and
// compares the outputs against hand-computed values.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ifu_fetch_if bus();

    ifu_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural memory state
    bit              mem_pending = 1'b0;
    int              mem_cnt     = 0;
    logic [PC_W-1:0] mem_addr    = '0;
    int              resp_delay  = 0;
    bit              err_en      = 1'b0;
    logic [PC_W-1:0] err_addr    = '0;
    int              req_count   = 0;

    // Memory contents: one fixed doubleword at the reset vector, elsewhere
    // the low word holds the doubleword address and the high word address+4,
    // so the expected instruction at any other PC is simply pc[31:0].
    function automatic logic [63:0] mem_read(input logic [PC_W-1:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0010_0093;
        return {a[31:0] + 32'd4, a[31:0]};
    endfunction

    // Advance one clock. Entered and left at negedge+1 with inputs settled.
    task automatic cycle();
        bit              req_fire;
        bit              resp_fire;
        logic [PC_W-1:0] addr;
        #1;
        req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        resp_fire = bus.imem_resp_valid && bus.imem_resp_ready;
        addr      = bus.imem_req_addr;
        @(posedge clk);
        @(negedge clk);
        if (resp_fire) mem_pending = 1'b0;
        if (req_fire) begin
            mem_pending = 1'b1;
            mem_cnt     = resp_delay;
            mem_addr    = addr;
            req_count++;
        end else if (mem_pending && mem_cnt > 0) begin
            mem_cnt--;
        end
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = mem_pending && (mem_cnt == 0);
        bus.imem_resp_data  = mem_pending ? mem_read(mem_addr) : 64'h0;
        bus.imem_resp_err   = mem_pending && err_en && (mem_addr == err_addr);
        #1;
    endtask

    // Step until if_valid is seen, bounded; reports cycles taken.
    task automatic wait_valid(input int max_cycles, output bit got, output int n);
        got = 1'b0;
        n   = 0;
        while (n < max_cycles) begin
            if (bus.if_valid) begin
                got = 1'b1;
                return;
            end
            cycle();
            n++;
        end
        got = bus.if_valid;
    endtask

    task automatic deliver();
        bus.if_ready = 1'b1;
        cycle();
        bus.if_ready = 1'b0;
    endtask

    task automatic redirect(input logic [PC_W-1:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
    endtask

    // Reset state, first fetch latency and the first two sequential bundles.
    task automatic test_reset();
        bit got;
        int n;
        rst = 1'b1;
        cycle();
        cycle();
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
        checks++; if (bus.imem_resp_ready !== 1'b0) begin failures++; $display("FAIL rst_resp_ready got=%b exp=0", bus.imem_resp_ready); end
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", bus.if_valid); end
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL first_req_addr got=%h exp=%h", bus.imem_req_addr, 64'h0000_0000_8000_0000); end
        resp_delay = 0;
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL first_bundle_timeout got=0 exp=1"); end
        checks++; if (n !== 2) begin failures++; $display("FAIL first_latency got=%0d exp=2", n); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL b0_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0000); end
        checks++; if (bus.if_inst !== 32'h0010_0093) begin failures++; $display("FAIL b0_inst got=%h exp=%h", bus.if_inst, 32'h0010_0093); end
        checks++; if (bus.if_fault !== 1'b0) begin failures++; $display("FAIL b0_fault got=%b exp=0", bus.if_fault); end
        deliver();
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL b1_timeout got=0 exp=1"); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0004) begin failures++; $display("FAIL b1_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0004); end
        checks++; if (bus.if_inst !== 32'h0000_0013) begin failures++; $display("FAIL b1_inst got=%h exp=%h", bus.if_inst, 32'h0000_0013); end
        checks++; if (bus.if_fault !== 1'b0) begin failures++; $display("FAIL b1_fault got=%b exp=0", bus.if_fault); end
        deliver();
    endtask

    // Decode stalls for 5 cycles: bundle stays stable and no new request goes out.
    task automatic test_stall();
        bit got;
        int n;
        int rc;
        bit stable;
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); end
        rc     = req_count;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0000_0000_8000_0008 ||
                bus.if_inst !== 32'h8000_0008 || bus.imem_req_valid !== 1'b0) begin
                stable = 1'b0;
                $display("FAIL stall_cycle%0d got valid=%b pc=%h inst=%h req=%b exp valid=1 pc=%h inst=%h req=0",
                         i, bus.if_valid, bus.if_pc, bus.if_inst, bus.imem_req_valid,
                         64'h0000_0000_8000_0008, 32'h8000_0008);
            end
        end
        checks++; if (!stable) failures++;
        checks++; if (req_count !== rc) begin failures++; $display("FAIL stall_req_count got=%0d exp=%0d", req_count, rc); end
        deliver();
    endtask

    // Redirect while the read is outstanding; the late response must be dropped.
    task automatic test_redirect_wait();
        bit got;
        int n;
        bit saw_valid;
        resp_delay = 3;
        cycle();
        checks++; if (bus.imem_resp_ready !== 1'b1) begin failures++; $display("FAIL rw_resp_ready got=%b exp=1", bus.imem_resp_ready); end
        redirect(64'h0000_0000_8000_0100);
        cycle();
        saw_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.imem_req_valid; i++) begin
            if (bus.if_valid) saw_valid = 1'b1;
            cycle();
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rw_stale_delivered got=1 exp=0"); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL rw_req_valid got=%b exp=1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 64'h0000_0000_8000_0100) begin failures++; $display("FAIL rw_req_addr got=%h exp=%h", bus.imem_req_addr, 64'h0000_0000_8000_0100); end
        resp_delay = 0;
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL rw_timeout got=0 exp=1"); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0100) begin failures++; $display("FAIL rw_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0100); end
        checks++; if (bus.if_inst !== 32'h8000_0100) begin failures++; $display("FAIL rw_inst got=%h exp=%h", bus.if_inst, 32'h8000_0100); end
        deliver();
    endtask

    // Redirect in the same cycle the response arrives: no bundle, refetch at target.
    task automatic test_redirect_resp();
        bit got;
        int n;
        resp_delay = 1;
        cycle();
        cycle();
        redirect(64'h0000_0000_8000_0200);
        cycle();
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rr_if_valid got=%b exp=0", bus.if_valid); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL rr_req_valid got=%b exp=1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 64'h0000_0000_8000_0200) begin failures++; $display("FAIL rr_req_addr got=%h exp=%h", bus.imem_req_addr, 64'h0000_0000_8000_0200); end
        resp_delay = 0;
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL rr_timeout got=0 exp=1"); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0200) begin failures++; $display("FAIL rr_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0200); end
        deliver();
    endtask

    // Misaligned redirect target: NOP with fault, no memory access; then a
    // redirect in S_OUT takes priority over delivery.
    task automatic test_misaligned();
        int rc;
        redirect(64'h0000_0000_8000_0102);
        cycle();
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_req_valid got=%b exp=0", bus.imem_req_valid); end
        rc = req_count;
        cycle();
        checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL mis_if_valid got=%b exp=1", bus.if_valid); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0102) begin failures++; $display("FAIL mis_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0102); end
        checks++; if (bus.if_inst !== 32'h0000_0013) begin failures++; $display("FAIL mis_inst got=%h exp=%h", bus.if_inst, 32'h0000_0013); end
        checks++; if (bus.if_fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", bus.if_fault); end
        checks++; if (req_count !== rc) begin failures++; $display("FAIL mis_req_count got=%0d exp=%0d", req_count, rc); end
        redirect(64'h0000_0000_8000_0008);
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL out_redirect_valid got=%b exp=0", bus.if_valid); end
        cycle();
        checks++; if (bus.imem_req_addr !== 64'h0000_0000_8000_0008 || bus.imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL out_redirect_req got valid=%b addr=%h exp valid=1 addr=%h", bus.imem_req_valid, bus.imem_req_addr, 64'h0000_0000_8000_0008);
        end
    endtask

    // Memory error flags the bundle; the following fetch is clean again.
    task automatic test_mem_error();
        bit got;
        int n;
        err_en   = 1'b1;
        err_addr = 64'h0000_0000_8000_0008;
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL err_timeout got=0 exp=1"); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0008) begin failures++; $display("FAIL err_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0008); end
        checks++; if (bus.if_fault !== 1'b1) begin failures++; $display("FAIL err_fault got=%b exp=1", bus.if_fault); end
        err_en = 1'b0;
        deliver();
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL noerr_timeout got=0 exp=1"); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_000c) begin failures++; $display("FAIL noerr_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_000c); end
        checks++; if (bus.if_inst !== 32'h8000_000c) begin failures++; $display("FAIL noerr_inst got=%h exp=%h", bus.if_inst, 32'h8000_000c); end
        checks++; if (bus.if_fault !== 1'b0) begin failures++; $display("FAIL noerr_fault got=%b exp=0", bus.if_fault); end
        deliver();
    endtask

    // PC increment wraps at the top of the address space.
    task automatic test_pc_wrap();
        bit got;
        int n;
        redirect(64'hffff_ffff_ffff_fffc);
        cycle();
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL wrap_timeout got=0 exp=1"); end
        checks++; if (bus.if_inst !== 32'hffff_fffc) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", bus.if_inst, 32'hffff_fffc); end
        deliver();
        checks++; if (bus.imem_req_addr !== 64'h0 || bus.imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_req got valid=%b addr=%h exp valid=1 addr=%h", bus.imem_req_valid, bus.imem_req_addr, 64'h0);
        end
    endtask

    // Reset while a read is outstanding; the late response must not be taken.
    task automatic test_reset_mid();
        bit got;
        int n;
        resp_delay = 1;
        cycle();
        rst = 1'b1;
        cycle();
        checks++; if (bus.imem_resp_ready !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got req=%b resp_ready=%b exp req=0 resp_ready=0", bus.imem_req_valid, bus.imem_resp_ready);
        end
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL midrst_req_valid got=%b exp=1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL midrst_req_addr got=%h exp=%h", bus.imem_req_addr, 64'h0000_0000_8000_0000); end
        checks++; if (bus.imem_resp_ready !== 1'b0) begin failures++; $display("FAIL midrst_resp_ready got=%b exp=0", bus.imem_resp_ready); end
        resp_delay = 0;
        wait_valid(20, got, n);
        checks++; if (!got) begin failures++; $display("FAIL midrst_timeout got=0 exp=1"); end
        checks++; if (bus.if_pc !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL midrst_pc got=%h exp=%h", bus.if_pc, 64'h0000_0000_8000_0000); end
        checks++; if (bus.if_inst !== 32'h0010_0093) begin failures++; $display("FAIL midrst_inst got=%h exp=%h", bus.if_inst, 32'h0010_0093); end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        bus.if_ready        = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_resp();
        test_misaligned();
        test_mem_error();
        test_pc_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the decode/control-generation stage.
- Owns the architectural fetch PC and issues one 64-bit instruction-memory read at a time.
- Extracts the 32-bit instruction word and hands {pc, inst, fault} to decode over a valid/ready handshake.
- Accepts PC redirects from branch/jump/trap resolution and discards any fetch made stale by a redirect.

Parameters:
- PC_W, 64, fetch PC and memory address width (matches register width).
- INST_W, 32, instruction width delivered to decode.
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  redirect request from execute/trap logic; one-cycle pulse.
- redirect_pc  in  PC_W  redirect target.
- imem_req_valid  out  1  memory read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  PC_W  request address: {pc[PC_W-1:3], 3'b000}.
- imem_resp_valid  in  1  read data valid.
- imem_resp_ready  out  1  fetch accepts the response.
- imem_resp_data  in  64  aligned doubleword.
- imem_resp_err  in  1  access fault on this response.
- if_valid  out  1  instruction bundle valid to decode.
- if_ready  in  1  decode accepts the bundle.
- if_pc  out  PC_W  PC of the delivered instruction.
- if_inst  out  INST_W  instruction word.
- if_fault  out  1  fetch fault (misaligned PC or memory error).

Behaviour:
- Registers: pc, state, drop (stale-response flag), inst_q, fault_q.
- Reset values: pc=RESET_PC, state=S_REQ, drop=0, inst_q=0, fault_q=0. While rst is high, imem_req_valid, imem_resp_ready and if_valid are all 0.
- FSM states S_REQ, S_WAIT, S_OUT, encoded 2 bits.
- S_REQ:
  - imem_req_valid = ~redirect_valid & (pc[1:0]==0).
  - redirect_valid: pc<=redirect_pc, stay in S_REQ; no request is issued this cycle.
  - Otherwise, if pc[1:0]!=0: inst_q<=NOP (32'h0000_0013), fault_q<=1, go to S_OUT. No memory access.
  - Otherwise, on imem_req_valid & imem_req_ready: go to S_WAIT. Otherwise hold.
- S_WAIT:
  - imem_resp_ready = 1.
  - redirect_valid without imem_resp_valid: pc<=redirect_pc, drop<=1, stay in S_WAIT.
  - imem_resp_valid with (drop | redirect_valid): discard the data, drop<=0, pc<=redirect_pc if redirect_valid, go to S_REQ.
  - imem_resp_valid otherwise: inst_q <= pc[2] ? data[63:32] : data[31:0], fault_q<=imem_resp_err, go to S_OUT.
- S_OUT:
  - if_valid = ~redirect_valid; if_pc=pc, if_inst=inst_q, if_fault=fault_q.
  - redirect_valid has priority: pc<=redirect_pc, go to S_REQ; the bundle is not delivered.
  - if_valid & if_ready: pc<=pc+4 (wraps modulo 2^PC_W), fault_q<=0, go to S_REQ.
  - Otherwise hold; outputs stay stable while stalled.
- Latency: at least 3 cycles per instruction with zero-wait memory (req, resp, out). Throughput is one instruction per 3 cycles; no prefetch.
- Exactly one outstanding memory request at any time; imem_req_valid is never asserted in S_WAIT or S_OUT.
- Fetch does not interpret the instruction. Decode resolves the branch and produces redirect_pc for non-sequential flow.
- Reset mid-transaction returns to S_REQ at RESET_PC. The memory side must tolerate the abandoned request; one late response is ignored because imem_resp_ready=0 outside S_WAIT.

Decomposition:
- defines.v holds shared constants:
  - RESET_PC
  - NOP encoding (32'h0000_0013)
  - FSM state encodings
  - the existing INSTWide/RegWidth widths, reused for INST_W/PC_W
- No sub-module. The half-word select and next-PC mux stay inline in ifu_fetch.

Test Plan:
1. Reset release, zero-wait memory returning 0x00000013_00100093 at 0x80000000 -> imem_req_addr=0x80000000; first bundle pc=0x80000000, inst=0x00100093; second bundle pc=0x80000004, inst=0x00000013, fault=0.
2. if_ready held low for 5 cycles in S_OUT -> if_valid, if_pc and if_inst constant for all 5 cycles; no new imem request issued.
3. redirect_valid to 0x80000100 while in S_WAIT, response arrives 2 cycles later -> response dropped; next request addr=0x80000100; delivered pc=0x80000100.
4. redirect_valid coincident with imem_resp_valid in S_WAIT, target 0x80000200 -> no bundle delivered; next request addr=0x80000200.
5. redirect_pc=0x80000102 -> no memory request; bundle pc=0x80000102, inst=0x00000013, fault=1.
6. imem_resp_err=1 on fetch at 0x80000008 -> bundle fault=1 with pc=0x80000008. rst asserted in S_WAIT -> next cycle state=S_REQ, pc=0x80000000.
